// File: rtl/decode_ctrl_pkg.sv
// Shared types and widths for the decode control slice: fetch packet layout and
// decode-control FSM states.
package decode_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  guess;
    logic [ADDR_WIDTH-1:0] pred;
    logic                  epoch;
  } fetch_pkt_t;

  typedef enum logic {
    DC_RUN,
    DC_REFILL
  } dec_ctrl_state_e;

endpackage

// File: rtl/decode_ctrl_if.sv
// Bundle of the fetch, decoder, rename, redirect and flush signals around decode_ctrl.
// The slave modport is the decode_ctrl view; master is the surrounding pipeline.
interface decode_ctrl_if
  import decode_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic                  i_fetch_valid;
  logic                  o_fetch_ready;
  logic [31:0]           i_fetch_instr;
  logic [ADDR_WIDTH-1:0] i_fetch_pc;
  logic                  i_fetch_guess;
  logic [ADDR_WIDTH-1:0] i_fetch_pred;
  logic                  i_fetch_epoch;
  logic [31:0]           o_dec_instr;
  logic [ADDR_WIDTH-1:0] o_dec_pc;
  logic                  o_dec_guess;
  logic [ADDR_WIDTH-1:0] o_dec_pred;
  logic                  i_dec_inconsistent;
  logic [ADDR_WIDTH-1:0] i_dec_new_pc;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic                  o_redirect_valid;
  logic [ADDR_WIDTH-1:0] o_redirect_pc;
  logic                  o_epoch;
  logic                  i_flush;
  logic [CNT_W-1:0]      o_redirect_cnt;

  modport slave (
    input  i_fetch_valid, i_fetch_instr, i_fetch_pc, i_fetch_guess, i_fetch_pred,
           i_fetch_epoch, i_dec_inconsistent, i_dec_new_pc, i_out_ready, i_flush,
    output o_fetch_ready, o_dec_instr, o_dec_pc, o_dec_guess, o_dec_pred,
           o_out_valid, o_redirect_valid, o_redirect_pc, o_epoch, o_redirect_cnt
  );

  modport master (
    output i_fetch_valid, i_fetch_instr, i_fetch_pc, i_fetch_guess, i_fetch_pred,
           i_fetch_epoch, i_dec_inconsistent, i_dec_new_pc, i_out_ready, i_flush,
    input  o_fetch_ready, o_dec_instr, o_dec_pc, o_dec_guess, o_dec_pred,
           o_out_valid, o_redirect_valid, o_redirect_pc, o_epoch, o_redirect_cnt
  );

endinterface

// File: rtl/decode_ctrl_fifo.sv
// Synchronous FIFO of fetch packets with a single-cycle clear; the head is read
// from registered storage, so a push is visible no earlier than the next cycle.
module fetch_pkt_fifo
  import decode_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_pkt_t               din,
  output fetch_pkt_t               head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_pkt_t        mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: pointers and count alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/decode_ctrl.sv
// Front-end decode sequencer: buffers fetch packets, feeds the decoder head,
// and issues fetch redirects with epoch-based squashing on branch inconsistency.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  decode_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  dec_ctrl_state_e       state;
  logic                  epoch;
  logic                  redir_valid;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic [CNT_W-1:0]      redir_cnt;

  fetch_pkt_t            din;
  fetch_pkt_t            head;
  logic                  empty;
  logic [CW-1:0]         count;

  logic                  fetch_ready;
  logic                  push;
  logic                  out_valid;
  logic                  pop;
  logic                  redirect;
  logic                  clear;

  assign fetch_ready = (count < CW'(DEPTH));
  assign push        = bus.i_fetch_valid && fetch_ready && (bus.i_fetch_epoch == epoch);
  // Every buffered entry carries the current epoch; the tag check is a cheap guard only.
  assign out_valid   = !empty && (state == DC_RUN) && (head.epoch == epoch);
  assign pop         = out_valid && bus.i_out_ready && !bus.i_flush;
  assign redirect    = pop && bus.i_dec_inconsistent;
  assign clear       = bus.i_flush || redirect;

  assign din = '{
    instr: bus.i_fetch_instr,
    pc:    bus.i_fetch_pc,
    guess: bus.i_fetch_guess,
    pred:  bus.i_fetch_pred,
    epoch: bus.i_fetch_epoch
  };

  fetch_pkt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DC_RUN;
      epoch       <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      redir_cnt   <= '0;
    end else begin
      redir_valid <= 1'b0;
      if (bus.i_flush) begin
        epoch <= ~epoch;
        state <= DC_REFILL;
      end else if (redirect) begin
        redir_valid <= 1'b1;
        redir_pc    <= bus.i_dec_new_pc;
        epoch       <= ~epoch;
        state       <= DC_REFILL;
        if (redir_cnt != '1) redir_cnt <= redir_cnt + 1'b1;
      end else if (state == DC_REFILL && push) begin
        state <= DC_RUN;
      end
    end
  end

  assign bus.o_fetch_ready    = fetch_ready;
  assign bus.o_dec_instr      = head.instr;
  assign bus.o_dec_pc         = head.pc;
  assign bus.o_dec_guess      = head.guess;
  assign bus.o_dec_pred       = head.pred;
  assign bus.o_out_valid      = out_valid;
  assign bus.o_redirect_valid = redir_valid;
  assign bus.o_redirect_pc    = redir_pc;
  assign bus.o_epoch          = epoch;
  assign bus.o_redirect_cnt   = redir_cnt;

endmodule
